vmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port video frame buffer (`vmem`). It shares the buffer between the VGA scan-out reader, which has absolute priority and is never stalled, and a pixel-write port used by drawing logic (keyboard/text engine). Writes pass through a small FIFO and use only idle memory cycles. A built-in clear engine fills the whole buffer with one colour.

---
 rtl/vmem_pkg.sv | 24 ++
 rtl/vmem_wr_fifo.sv | 47 ++++
 rtl/vmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_vmem_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared defaults, address packing and clear-FSM states for the
// video frame buffer arbiter.
package vmem_pkg;

  localparam int DEF_H_BITS = 10;
  localparam int DEF_V_BITS = 9;
  localparam int DEF_DATA_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2
  } clr_state_t;

  // Frame buffer address is {h, v}, h in the MSBs.
  function automatic logic [31:0] pack_addr(
    input logic [31:0] h,
    input logic [31:0] v,
    input int unsigned v_bits
  );
    return (h << v_bits) | v;
  endfunction

endpackage

// File: rtl/vmem_wr_fifo.sv
// Small synchronous write FIFO for queued pixel writes,
// pointers with wrap bit and asynchronous reset.
module vmem_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] store [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr[PW-1:0]] <= din;
  end

  assign head  = store[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/vmem_arbiter.sv
// Single-port frame buffer arbiter: scan-out reads first, then
// clear-engine fill, then queued pixel writes on idle cycles.
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int H_BITS     = DEF_H_BITS,
  parameter int V_BITS     = DEF_V_BITS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     scan_req,
  input  logic [H_BITS-1:0]        scan_h,
  input  logic [V_BITS-1:0]        scan_v,
  output logic                     scan_valid,
  output logic [DATA_W-1:0]        scan_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [H_BITS-1:0]        wr_h,
  input  logic [V_BITS-1:0]        wr_v,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_start,
  input  logic [DATA_W-1:0]        clr_color,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [H_BITS+V_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int ADDR_W = H_BITS + V_BITS;
  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_col;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              grant_fill;
  logic              grant_fifo;
  logic              scan_d1;

  assign scan_addr = ADDR_W'(pack_addr(32'(scan_h), 32'(scan_v), V_BITS));
  assign wr_addr   = ADDR_W'(pack_addr(32'(wr_h), 32'(wr_v), V_BITS));

  assign wr_ready   = !reset && !fifo_full && (state == ST_IDLE);
  assign fifo_push  = wr_valid && wr_ready;
  assign grant_fill = !scan_req && (state == ST_FILL);
  assign grant_fifo = !scan_req && (state != ST_FILL) && !fifo_empty;
  assign clr_busy   = (state != ST_IDLE);

  vmem_wr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (grant_fifo),
    .din   ({wr_addr, wr_data}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs are forced idle while reset is held, even if scan asks.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      unique case (1'b1)
        scan_req: begin
          mem_en   = 1'b1;
          mem_addr = scan_addr;
        end
        grant_fill: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = clr_cnt;
          mem_wdata = clr_col;
        end
        grant_fifo: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = fifo_head[ENT_W-1:DATA_W];
          mem_wdata = fifo_head[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      clr_cnt  <= '0;
      clr_col  <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state   <= ST_DRAIN;
            clr_col <= clr_color;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state <= ST_FILL;
        end
        ST_FILL: begin
          if (grant_fill) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST) begin
              state    <= ST_IDLE;
              clr_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request stage, then memory read stage, then data register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_d1    <= 1'b0;
      scan_valid <= 1'b0;
      scan_data  <= '0;
    end else begin
      scan_d1    <= scan_req;
      scan_valid <= scan_d1;
      if (scan_d1) scan_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed bench for vmem_arbiter with a small 16x8 frame buffer
// model behind the memory port.
module tb_vmem_arbiter;

  localparam int HB = 4;
  localparam int VB = 3;
  localparam int DW = 24;
  localparam int AW = HB + VB;

  logic          clock;
  logic          reset;
  logic          scan_req;
  logic [HB-1:0] scan_h;
  logic [VB-1:0] scan_v;
  logic          scan_valid;
  logic [DW-1:0] scan_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [HB-1:0] wr_h;
  logic [VB-1:0] wr_v;
  logic [DW-1:0] wr_data;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] vram [1 << AW];

  int checks;
  int fails;

  vmem_arbiter #(
    .H_BITS     (HB),
    .V_BITS     (VB),
    .DATA_W     (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_req   (scan_req),
    .scan_h     (scan_h),
    .scan_v     (scan_v),
    .scan_valid (scan_valid),
    .scan_data  (scan_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_h       (wr_h),
    .wr_v       (wr_v),
    .wr_data    (wr_data),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        mem_rdata <= vram[mem_addr];
    end
  end

  typedef struct {
    logic          sreq;
    logic [HB-1:0] sh;
    logic [VB-1:0] sv;
    logic          wv;
    logic [HB-1:0] wh;
    logic [VB-1:0] wvv;
    logic [DW-1:0] wd;
    logic          e_rdy;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_sval;
    logic          chk_sd;
    logic [DW-1:0] e_sd;
  } vec_t;

  vec_t vec [11];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clock);
  endtask

  task automatic to_pos();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    scan_req  = 1'b0;
    scan_h    = '0;
    scan_v    = '0;
    wr_valid  = 1'b0;
    wr_h      = '0;
    wr_v      = '0;
    wr_data   = '0;
    clr_start = 1'b0;
    clr_color = '0;
  endtask

  function automatic logic [AW-1:0] pk(input int h, input int v);
    return AW'((h << VB) | v);
  endfunction

  task automatic do_scan(input int h, input int v,
                         input logic [DW-1:0] exp,
                         input string name);
    scan_req = 1'b1;
    scan_h   = HB'(h);
    scan_v   = VB'(v);
    to_neg();
    to_pos();
    scan_req = 1'b0;
    to_neg();
    to_pos();
    to_neg();
    check({name, "_val"}, 64'(scan_valid), 64'(1));
    check({name, "_dat"}, 64'(scan_data), 64'(exp));
    to_pos();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_n;
    int fill_n;
    int fill_bad;
    int dn;
    int first;
    int rdy_bad;
    int busy_bad;
    int dc;

    checks = 0;
    fails  = 0;
    idle_in();

    vec[0]  = '{0,0,0, 0,0,0,24'h0,      1,0,0,7'h00,24'h0,      0,0,24'h0};
    vec[1]  = '{0,0,0, 1,5,3,24'hFF0000, 1,0,0,7'h00,24'h0,      0,0,24'h0};
    vec[2]  = '{0,0,0, 0,0,0,24'h0,      1,1,1,7'h2B,24'hFF0000, 0,0,24'h0};
    vec[3]  = '{1,5,3, 0,0,0,24'h0,      1,1,0,7'h2B,24'h0,      0,0,24'h0};
    vec[4]  = '{1,1,2, 1,2,1,24'h123456, 1,1,0,7'h0A,24'h0,      0,0,24'h0};
    vec[5]  = '{1,0,0, 0,0,0,24'h0,      1,1,0,7'h00,24'h0,      1,1,24'hFF0000};
    vec[6]  = '{0,0,0, 0,0,0,24'h0,      1,1,1,7'h11,24'h123456, 1,0,24'h0};
    vec[7]  = '{0,0,0, 0,0,0,24'h0,      1,0,0,7'h00,24'h0,      1,0,24'h0};
    vec[8]  = '{1,2,1, 0,0,0,24'h0,      1,1,0,7'h11,24'h0,      0,0,24'h0};
    vec[9]  = '{0,0,0, 0,0,0,24'h0,      1,0,0,7'h00,24'h0,      0,0,24'h0};
    vec[10] = '{0,0,0, 0,0,0,24'h0,      1,0,0,7'h00,24'h0,      1,1,24'h123456};

    // Reset held with a scan request present: outputs stay idle.
    reset    = 1'b1;
    scan_req = 1'b1;
    scan_h   = 4'd5;
    scan_v   = 3'd3;
    to_neg();
    check("rst_en",    64'(mem_en),     64'(0));
    check("rst_we",    64'(mem_we),     64'(0));
    check("rst_addr",  64'(mem_addr),   64'(0));
    check("rst_wdata", 64'(mem_wdata),  64'(0));
    check("rst_rdy",   64'(wr_ready),   64'(0));
    check("rst_sval",  64'(scan_valid), 64'(0));
    check("rst_sdata", 64'(scan_data),  64'(0));
    check("rst_busy",  64'(clr_busy),   64'(0));
    check("rst_done",  64'(clr_done),   64'(0));
    to_pos();
    idle_in();
    to_pos();
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      scan_req = vec[i].sreq;
      scan_h   = vec[i].sh;
      scan_v   = vec[i].sv;
      wr_valid = vec[i].wv;
      wr_h     = vec[i].wh;
      wr_v     = vec[i].wvv;
      wr_data  = vec[i].wd;
      to_neg();
      check($sformatf("v%0d_rdy", i), 64'(wr_ready), 64'(vec[i].e_rdy));
      check($sformatf("v%0d_en", i), 64'(mem_en), 64'(vec[i].e_en));
      check($sformatf("v%0d_we", i), 64'(mem_we), 64'(vec[i].e_we));
      check($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(vec[i].e_addr));
      check($sformatf("v%0d_wd", i), 64'(mem_wdata), 64'(vec[i].e_wd));
      check($sformatf("v%0d_sval", i), 64'(scan_valid), 64'(vec[i].e_sval));
      if (vec[i].chk_sd)
        check($sformatf("v%0d_sdat", i), 64'(scan_data), 64'(vec[i].e_sd));
      to_pos();
    end
    idle_in();

    // Scan held for 10 cycles while four writes fill the FIFO.
    for (int i = 0; i < 10; i++) begin
      scan_req = 1'b1;
      scan_h   = HB'(i);
      scan_v   = '0;
      wr_valid = (i < 4);
      wr_h     = HB'(i + 1);
      wr_v     = VB'(i);
      wr_data  = 24'hB00000 + DW'(i);
      to_neg();
      check($sformatf("b%0d_nowe", i), 64'(mem_we), 64'(0));
      check($sformatf("b%0d_rdy", i), 64'(wr_ready), 64'(i < 4));
      to_pos();
    end
    idle_in();
    for (int k = 0; k < 4; k++) begin
      to_neg();
      check($sformatf("b_ret%0d_we", k), 64'(mem_we), 64'(1));
      check($sformatf("b_ret%0d_addr", k), 64'(mem_addr), 64'(pk(k + 1, k)));
      check($sformatf("b_ret%0d_wd", k), 64'(mem_wdata),
            64'(24'hB00000 + DW'(k)));
      to_pos();
    end
    to_neg();
    check("b_after_en", 64'(mem_en), 64'(0));
    to_pos();

    // Clear with two writes still queued behind a scan.
    scan_req = 1'b1;
    wr_valid = 1'b1;
    wr_h = 4'd3; wr_v = 3'd1; wr_data = 24'h0000C1;
    to_pos();
    wr_h = 4'd4; wr_v = 3'd2; wr_data = 24'h0000C2;
    to_pos();
    idle_in();
    we_n = 0; fill_n = 0; fill_bad = 0; dn = 0; first = -1;
    for (int c = 0; c < 400; c++) begin
      clr_start = (c == 0);
      clr_color = 24'h00FF00;
      to_neg();
      if (c == 1) check("c_busy", 64'(clr_busy), 64'(1));
      if (mem_we) begin
        if (we_n == 0) begin
          check("c_q0_addr", 64'(mem_addr), 64'(pk(3, 1)));
          check("c_q0_wd", 64'(mem_wdata), 64'(24'h0000C1));
        end else if (we_n == 1) begin
          check("c_q1_addr", 64'(mem_addr), 64'(pk(4, 2)));
          check("c_q1_wd", 64'(mem_wdata), 64'(24'h0000C2));
        end else begin
          if (mem_addr != AW'(fill_n) || mem_wdata != 24'h00FF00)
            fill_bad++;
          fill_n++;
        end
        we_n++;
      end
      if (clr_done) begin
        dn++;
        if (first < 0) first = c;
      end
      to_pos();
      if (first >= 0 && c >= first + 4) break;
    end
    idle_in();
    check("c_done_cycle", 64'(first), 64'(131));
    check("c_done_count", 64'(dn), 64'(1));
    check("c_fill_count", 64'(fill_n), 64'(128));
    check("c_fill_bad", 64'(fill_bad), 64'(0));
    for (int j = 0; j < 5; j++)
      do_scan($urandom_range(0, 15), $urandom_range(0, 7),
              24'h00FF00, $sformatf("c_scan%0d", j));

    // Clear of an empty FIFO with a second start, a waiting write
    // and three scan cycles stealing FILL slots.
    rdy_bad = 0; busy_bad = 0; dc = -1;
    for (int c = 0; c < 400; c++) begin
      clr_start = (c == 0 || c == 5);
      clr_color = (c == 0) ? 24'h112233 : 24'h0000FF;
      scan_req  = (c >= 20 && c <= 22);
      scan_h    = 4'd1;
      scan_v    = 3'd1;
      wr_valid  = (c >= 1) && (dc < 0);
      wr_h      = 4'd7;
      wr_v      = 3'd7;
      wr_data   = 24'hABCDEF;
      to_neg();
      if (dc >= 0) begin
        check("d_pw_done", 64'(clr_done), 64'(0));
        check("d_pw_we", 64'(mem_we), 64'(1));
        check("d_pw_addr", 64'(mem_addr), 64'(pk(7, 7)));
        check("d_pw_wd", 64'(mem_wdata), 64'(24'hABCDEF));
        to_pos();
        break;
      end
      if (clr_done) begin
        dc = c;
        check("d_rdy_at_done", 64'(wr_ready), 64'(1));
      end else if (c >= 1) begin
        if (wr_ready) rdy_bad++;
        if (!clr_busy) busy_bad++;
      end
      to_pos();
    end
    idle_in();
    check("d_done_cycle", 64'(dc), 64'(133));
    check("d_rdy_low", 64'(rdy_bad), 64'(0));
    check("d_busy_high", 64'(busy_bad), 64'(0));
    do_scan(1, 1, 24'h112233, "d_scan_col");
    do_scan(7, 7, 24'hABCDEF, "d_scan_wr");

    // Reset in the middle of FILL, then a fresh clear.
    for (int c = 0; c < 30; c++) begin
      clr_start = (c == 0);
      clr_color = 24'hEEEEEE;
      to_pos();
    end
    idle_in();
    #1;
    check("e_pre_we", 64'(mem_we), 64'(1));
    check("e_pre_busy", 64'(clr_busy), 64'(1));
    scan_req = 1'b1;
    reset    = 1'b1;
    #1;
    check("e_rst_en", 64'(mem_en), 64'(0));
    check("e_rst_we", 64'(mem_we), 64'(0));
    check("e_rst_addr", 64'(mem_addr), 64'(0));
    check("e_rst_wd", 64'(mem_wdata), 64'(0));
    check("e_rst_rdy", 64'(wr_ready), 64'(0));
    check("e_rst_busy", 64'(clr_busy), 64'(0));
    check("e_rst_sval", 64'(scan_valid), 64'(0));
    check("e_rst_sdat", 64'(scan_data), 64'(0));
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      if (clr_done) dn++;
      to_pos();
    end
    check("e_no_done", 64'(dn), 64'(0));
    idle_in();
    reset = 1'b0;
    to_neg();
    check("e_rel_rdy", 64'(wr_ready), 64'(1));
    to_pos();
    first = -1; dn = -1;
    for (int c = 0; c < 400; c++) begin
      clr_start = (c == 0);
      clr_color = 24'h0A0B0C;
      to_neg();
      if (mem_we && first < 0) begin
        first = c;
        check("e_first_addr", 64'(mem_addr), 64'(0));
        check("e_first_wd", 64'(mem_wdata), 64'(24'h0A0B0C));
      end
      if (clr_done) begin
        dn = c;
        to_pos();
        break;
      end
      to_pos();
    end
    idle_in();
    check("e_first_cycle", 64'(first), 64'(2));
    check("e_done_cycle", 64'(dn), 64'(130));
    do_scan(3, 3, 24'h0A0B0C, "e_scan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
